// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, the default
// reset vector and the counter-width helper.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      PCWR    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } state_t;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_1000;

   // Width needed to hold the larger of the two programmable intervals.
   function automatic int cnt_width(input int hold_cycles, input int stage_gap);
      int m;
      m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable up-counter with synchronous clear and terminal-count flag.
// Saturates at all ones so it can never wrap back into range.
module reset_seq_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] term,
   output logic         tc
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] cnt;

   // Counter register: clear beats load beats increment.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (inc && (cnt != MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == term);

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: holds the core, pulses the reset-vector write to r_pc,
// then releases N_CH downstream resets in ascending order.
// Optional feature macro RESET_SEQ_BOOTSEL_EN adds BOOT_SEL / ALT_VEC to
// choose an alternate boot vector, sampled on the HOLD->PCWR edge.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
   parameter int              N_CH        = 3,
   parameter int              HOLD_CYCLES = 4,
   parameter int              STAGE_GAP   = 2
`ifdef RESET_SEQ_BOOTSEL_EN
   ,parameter logic [XLEN-1:0] ALT_VEC    = '0
`endif
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ACT,
`ifdef RESET_SEQ_BOOTSEL_EN
   input  logic            BOOT_SEL,
`endif
   output logic [XLEN-1:0] r_pc_D,
   output logic            r_pc_WE,
   output logic [N_CH-1:0] rst_out,
   output logic            BUSY,
   output logic            DONE
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
   localparam int CH_W  = $clog2(N_CH + 1);

   state_t            state, state_nx;
   logic [CH_W-1:0]   ch, ch_nx;
   logic [N_CH-1:0]   rst_out_nx;
   logic [N_CH-1:0]   ch_mask;
   logic [XLEN-1:0]   r_pc_D_nx;
   logic [XLEN-1:0]   pc_vec;
   logic              r_pc_WE_nx;
   logic              busy_nx;
   logic              done_nx;
   logic              t_clr;
   logic              t_inc;
   logic              t_tc;
   logic [CNT_W-1:0]  t_term;

`ifdef RESET_SEQ_BOOTSEL_EN
   assign pc_vec = BOOT_SEL ? ALT_VEC : RESET_VEC;
`else
   assign pc_vec = RESET_VEC;
`endif

   assign ch_mask = N_CH'(1) << ch;

   reset_seq_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk      (CLK),
      .rst      (RST),
      .clr      (t_clr),
      .load     (1'b0),
      .inc      (t_inc),
      .load_val ('0),
      .term     (t_term),
      .tc       (t_tc)
   );

   // Next-state and next-output logic; ACT overrides every transition.
   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      state_nx   = state;
      ch_nx      = ch;
      rst_out_nx = rst_out;
      r_pc_WE_nx = 1'b0;
      r_pc_D_nx  = '0;
      busy_nx    = BUSY;
      done_nx    = DONE;
      t_clr      = 1'b0;
      t_inc      = 1'b0;
      t_term     = (state == RELEASE) ? CNT_W'(STAGE_GAP - 1) : CNT_W'(HOLD_CYCLES - 1);

      if (ACT) begin
         state_nx   = HOLD;
         ch_nx      = '0;
         rst_out_nx = '1;
         busy_nx    = 1'b1;
         done_nx    = 1'b0;
         t_clr      = 1'b1;
      end else begin
         case (state)
            HOLD: begin
               if (t_tc) begin
                  state_nx   = PCWR;
                  r_pc_WE_nx = 1'b1;
                  r_pc_D_nx  = pc_vec;
                  t_clr      = 1'b1;
               end else begin
                  t_inc = 1'b1;
               end
            end
            PCWR: begin
               // ch is 0 here, so the mask releases channel 0.
               rst_out_nx = rst_out & ~ch_mask;
               ch_nx      = CH_W'(1);
               t_clr      = 1'b1;
               if (N_CH == 1) begin
                  state_nx = RUN;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = RELEASE;
               end
            end
            RELEASE: begin
               if (t_tc) begin
                  rst_out_nx = rst_out & ~ch_mask;
                  ch_nx      = ch + CH_W'(1);
                  t_clr      = 1'b1;
                  if (ch == CH_W'(N_CH - 1)) begin
                     state_nx = RUN;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
                  end
               end else begin
                  t_inc = 1'b1;
               end
            end
            RUN: begin
               state_nx = RUN;
            end
            default: begin
               state_nx = HOLD;
            end
         endcase
      end
   end

   // State and registered outputs, reset asynchronously to the hold condition.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= HOLD;
         ch      <= '0;
         rst_out <= '1;
         r_pc_WE <= 1'b0;
         r_pc_D  <= '0;
         BUSY    <= 1'b1;
         DONE    <= 1'b0;
      end else begin
         state   <= state_nx;
         ch      <= ch_nx;
         rst_out <= rst_out_nx;
         r_pc_WE <= r_pc_WE_nx;
         r_pc_D  <= r_pc_D_nx;
         BUSY    <= busy_nx;
         DONE    <= done_nx;
      end
   end

endmodule
